ride_dispatch_scheduler: RTL and testbench

- Shares the single launch track between up to N_TRAIN trains waiting at loading platforms.
- Grants one train at a time, round-robin, and only when lift block 1 and block 2 are clear.
- Holds the grant until the train is confirmed on block 1, then enforces a minimum headway before the next launch.
- Sits above the per-train ride controllers and drives their launch-enable inputs; E-stop or a launch timeout latches a fault.

---
 rtl/ride_dispatch_scheduler.sv | 146 ++++++++++++++
 tb/tb_ride_dispatch_scheduler.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ride_dispatch_scheduler.sv
// Round-robin launch-track arbiter with block interlock, launch timeout and post-launch headway.
// Optional DISPATCH_COUNT_EN macro enables the saturating confirmed-launch counter.
module ride_dispatch_scheduler #(
    parameter int unsigned N_TRAIN          = 4,
    parameter int unsigned HEADWAY_CYC      = 16,
    parameter int unsigned DISPATCH_TIMEOUT = 255,
    parameter int unsigned CNT_W            = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_TRAIN-1:0] i_req,
    input  logic [4:0]         i_block_occ,
    input  logic               i_estop,
    input  logic               i_fault_clr,
    output logic [N_TRAIN-1:0] o_grant,
    output logic [1:0]         o_state,
    output logic               o_fault,
    output logic               o_timeout,
    output logic [15:0]        o_dispatch_cnt
);

    localparam int unsigned PTR_W = $clog2(N_TRAIN);
    localparam logic [N_TRAIN-1:0] GRANT_ONE = N_TRAIN'(1);

    typedef enum logic [1:0] {
        StIdle     = 2'b00,
        StDispatch = 2'b01,
        StHeadway  = 2'b10,
        StFault    = 2'b11
    } state_e;

    state_e             state_q;
    logic [N_TRAIN-1:0] grant_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   win_q;
    logic               timeout_q;

    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   ptr_next;
    logic               path_clear;
    logic               unused_occ;

    assign path_clear = !i_block_occ[1] && !i_block_occ[2];
    assign unused_occ = ^{i_block_occ[4:3], i_block_occ[0]};

    // First requester at or above the pointer, wrapping past N_TRAIN-1.
    always_comb begin
        int unsigned cand;
        win_vld = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int unsigned i = 0; i < N_TRAIN; i++) begin
            cand = (32'(ptr_q) + i) % N_TRAIN;
            if (!win_vld && i_req[cand[PTR_W-1:0]]) begin
                win_vld = 1'b1;
                win_idx = cand[PTR_W-1:0];
            end
        end
    end

    assign ptr_next = (win_q == PTR_W'(N_TRAIN - 1)) ? '0 : win_q + PTR_W'(1);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            grant_q   <= '0;
            cnt_q     <= '0;
            ptr_q     <= '0;
            win_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (i_estop) begin
                        state_q <= StFault;
                    end else if (win_vld && path_clear) begin
                        grant_q <= GRANT_ONE << win_idx;
                        win_q   <= win_idx;
                        cnt_q   <= '0;
                        state_q <= StDispatch;
                    end
                end
                StDispatch: begin
                    if (i_estop) begin
                        state_q <= StFault;
                        grant_q <= '0;
                    end else if (i_block_occ[1]) begin
                        state_q <= StHeadway;
                        grant_q <= '0;
                        cnt_q   <= '0;
                        ptr_q   <= ptr_next;
                    end else if (cnt_q == CNT_W'(DISPATCH_TIMEOUT - 1)) begin
                        state_q   <= StFault;
                        timeout_q <= 1'b1;
                        grant_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StHeadway: begin
                    if (i_estop) begin
                        state_q <= StFault;
                    end else if (cnt_q == CNT_W'(HEADWAY_CYC - 1)) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                StFault: begin
                    if (i_fault_clr && !i_estop) begin
                        state_q   <= StIdle;
                        timeout_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign o_grant   = grant_q;
    assign o_state   = state_q;
    assign o_fault   = (state_q == StFault);
    assign o_timeout = timeout_q;

`ifdef DISPATCH_COUNT_EN
    logic        confirm;
    logic [15:0] disp_cnt_q;

    assign confirm = (state_q == StDispatch) && !i_estop && i_block_occ[1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            disp_cnt_q <= '0;
        end else if (confirm && disp_cnt_q != 16'hFFFF) begin
            disp_cnt_q <= disp_cnt_q + 16'd1;
        end
    end

    assign o_dispatch_cnt = disp_cnt_q;
`else
    assign o_dispatch_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ride_dispatch_scheduler.sv
// Self-checking bench for ride_dispatch_scheduler: directed scenarios plus random traffic
// compared every cycle against a behavioural model of the dispatch rules.
module tb_ride_dispatch_scheduler;

    localparam int N  = 4;
    localparam int HW = 16;
    localparam int TO = 255;
    localparam int CW = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [4:0]   occ;
    logic         estop;
    logic         fclr;
    logic [N-1:0] grant;
    logic [1:0]   state;
    logic         fault;
    logic         tmo;
    logic [15:0]  dcnt;

    always #5 clk = ~clk;

    ride_dispatch_scheduler #(
        .N_TRAIN         (N),
        .HEADWAY_CYC     (HW),
        .DISPATCH_TIMEOUT(TO),
        .CNT_W           (CW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .i_block_occ   (occ),
        .i_estop       (estop),
        .i_fault_clr   (fclr),
        .o_grant       (grant),
        .o_state       (state),
        .o_fault       (fault),
        .o_timeout     (tmo),
        .o_dispatch_cnt(dcnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: mode uses the published state codes; dwell counts cycles spent in the current phase.
    int m_mode  = 0;
    int m_win   = -1;
    int m_dwell = 0;
    int m_ptr   = 0;
    int m_tmo   = 0;
    int m_cnt   = 0;

    task automatic model_step(input logic [N-1:0] r, input logic [4:0] o, input logic es,
                              input logic clr, input logic rs);
        if (rs) begin
            m_mode = 0; m_win = -1; m_dwell = 0; m_ptr = 0; m_tmo = 0; m_cnt = 0;
            return;
        end
        case (m_mode)
            0: begin
                if (es) begin
                    m_mode = 3;
                end else if (r != 0 && !o[1] && !o[2]) begin
                    for (int j = 0; j < N; j++) begin
                        int t;
                        t = (m_ptr + j) % N;
                        if (m_win < 0 && r[t]) m_win = t;
                    end
                    m_dwell = 0;
                    m_mode  = 1;
                end
            end
            1: begin
                if (es) begin
                    m_mode = 3; m_win = -1;
                end else if (o[1]) begin
                    m_ptr   = (m_win + 1) % N;
                    m_win   = -1;
                    m_dwell = 0;
                    m_mode  = 2;
`ifdef DISPATCH_COUNT_EN
                    if (m_cnt < 65535) m_cnt++;
`endif
                end else begin
                    m_dwell++;
                    if (m_dwell == TO) begin
                        m_mode = 3; m_tmo = 1; m_win = -1;
                    end
                end
            end
            2: begin
                if (es) begin
                    m_mode = 3;
                end else begin
                    m_dwell++;
                    if (m_dwell == HW) m_mode = 0;
                end
            end
            default: begin
                if (clr && !es) begin
                    m_mode = 0; m_tmo = 0;
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_val("grant", 32'(grant), (m_win >= 0) ? (32'd1 << m_win) : 32'd0);
        check_val("state", 32'(state), 32'(m_mode));
        check_val("fault", 32'(fault), 32'(m_mode == 3));
        check_val("timeout", 32'(tmo), 32'(m_tmo));
        check_val("dispatch_cnt", 32'(dcnt), 32'(m_cnt));
        check_val("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    endtask

    task automatic tick(input logic [N-1:0] r, input logic [4:0] o, input logic es,
                        input logic clr, input logic rs);
        req = r; occ = o; estop = es; fclr = clr; rst = rs;
        @(posedge clk);
        model_step(r, o, es, clr, rs);
        #1;
        compare_all();
    endtask

    logic [N-1:0] exp_rr [5];
    logic [N-1:0] r_r;
    logic [4:0]   r_o;

    initial begin
        exp_rr[0] = 4'b0001; exp_rr[1] = 4'b0010; exp_rr[2] = 4'b0100;
        exp_rr[3] = 4'b1000; exp_rr[4] = 4'b0001;

        // Reset
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_fault", 32'(fault), 32'd0);
        check_val("rst_timeout", 32'(tmo), 32'd0);
        check_val("rst_cnt", 32'(dcnt), 32'd0);

        // Round-robin order with exact headway timing
        tick(4'b1111, '0, 1'b0, 1'b0, 1'b0);
        check_val("rr_grant0", 32'(grant), 32'(exp_rr[0]));
        for (int k = 0; k < 5; k++) begin
            tick(4'b1111, 5'b00010, 1'b0, 1'b0, 1'b0);
            check_val("hw_enter", 32'(state), 32'd2);
            for (int c = 0; c < HW - 1; c++) begin
                tick(4'b1111, '0, 1'b0, 1'b0, 1'b0);
                check_val("hw_hold", 32'(state), 32'd2);
            end
            if (k < 4) begin
                tick(4'b1111, '0, 1'b0, 1'b0, 1'b0);
                check_val("hw_idle", 32'(state), 32'd0);
                check_val("hw_idle_grant", 32'(grant), 32'd0);
                tick(4'b1111, '0, 1'b0, 1'b0, 1'b0);
                check_val("rr_grant", 32'(grant), 32'(exp_rr[k+1]));
            end
        end
`ifdef DISPATCH_COUNT_EN
        check_val("rr_count", 32'(dcnt), 32'd5);
`else
        check_val("rr_count", 32'(dcnt), 32'd0);
`endif

        // Block interlock
        tick('0, '0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 50; c++) begin
            tick(4'b0100, 5'b00100, 1'b0, 1'b0, 1'b0);
            check_val("interlock_hold", 32'(grant), 32'd0);
        end
        tick(4'b0100, '0, 1'b0, 1'b0, 1'b0);
        check_val("interlock_release", 32'(grant), 32'b0100);

        // Launch timeout
        for (int c = 0; c < TO - 1; c++) begin
            tick(4'b0100, '0, 1'b0, 1'b0, 1'b0);
            check_val("to_wait", 32'(state), 32'd1);
        end
        tick(4'b0100, '0, 1'b0, 1'b0, 1'b0);
        check_val("to_state", 32'(state), 32'd3);
        check_val("to_fault", 32'(fault), 32'd1);
        check_val("to_flag", 32'(tmo), 32'd1);
        check_val("to_grant", 32'(grant), 32'd0);
        tick('0, '0, 1'b1, 1'b1, 1'b0);
        check_val("clr_estop", 32'(state), 32'd3);
        tick('0, '0, 1'b0, 1'b1, 1'b0);
        check_val("clr_state", 32'(state), 32'd0);
        check_val("clr_timeout", 32'(tmo), 32'd0);

        // Simultaneous estop and occupancy
        tick(4'b0001, '0, 1'b0, 1'b0, 1'b0);
        check_val("sim_grant", 32'(grant), 32'b0001);
        tick(4'b0001, 5'b00010, 1'b1, 1'b0, 1'b0);
        check_val("sim_state", 32'(state), 32'd3);
        check_val("sim_timeout", 32'(tmo), 32'd0);
        check_val("sim_cnt", 32'(dcnt), 32'd0);
        tick('0, '0, 1'b0, 1'b1, 1'b0);

        // Reset mid-dispatch
        tick(4'b0010, '0, 1'b0, 1'b0, 1'b0);
        check_val("mid_grant", 32'(grant), 32'b0010);
        tick(4'b0010, '0, 1'b0, 1'b0, 1'b1);
        check_val("mid_rst_grant", 32'(grant), 32'd0);
        check_val("mid_rst_state", 32'(state), 32'd0);
        tick(4'b0011, '0, 1'b0, 1'b0, 1'b0);
        check_val("mid_ptr", 32'(grant), 32'b0001);

        // Random traffic; every third window suppresses confirmation so timeouts occur
        for (int c = 0; c < 3000; c++) begin
            r_r = N'($urandom);
            if ($urandom_range(0, 3) == 0) r_r = '0;
            r_o = 5'($urandom) & 5'b11001;
            if ((c / 300) % 3 != 2 && $urandom_range(0, 5) == 0) r_o[1] = 1'b1;
            if ($urandom_range(0, 5) == 0) r_o[2] = 1'b1;
            tick(r_r, r_o, ($urandom_range(0, 99) == 0), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 499) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
